// File: rtl/sd_sector_reader.sv
// Drains one SD sector RAM into 32-bit little-endian words.
// Also accumulates a 16-bit additive checksum of the sector.
module sd_sector_reader #(
  parameter int BYTE_COUNT = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_done,
  input  logic        read_finish,
  output logic [8:0]  raddr,
  input  logic [7:0]  rdata,
  output logic [31:0] word_data,
  output logic        word_valid,
  output logic        word_last,
  input  logic        word_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] checksum,
  output logic        overrun
);

  localparam int NWORDS = BYTE_COUNT / 4;
  localparam logic [7:0] LAST_IDX = 8'(NWORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_OUT,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [8:0]  r_addr;
  logic [8:0]  r_raddr;
  logic [7:0]  r_widx;
  logic [31:0] r_word;
  logic [15:0] r_sum;
  logic        r_rf_prev;
  logic        r_ovr;

  logic w_rise;
  logic w_start;
  logic w_hs;
  logic w_last;

  assign w_rise  = read_finish & ~r_rf_prev;
  assign w_start = w_rise & init_done
                 & (r_state == S_IDLE);
  assign w_hs    = (r_state == S_OUT) & word_ready;
  assign w_last  = (r_widx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_start) w_next = S_RD;
      S_RD:   w_next = S_CAP;
      S_CAP:  w_next = (r_addr[1:0] == 2'd3)
                     ? S_OUT : S_RD;
      S_OUT:  if (w_hs) w_next = w_last
                     ? S_DONE : S_RD;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    word_valid = (r_state == S_OUT);
    word_last  = word_valid & w_last;
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
  end

  // prev starts at 1 so a level held across reset never starts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rf_prev <= 1'b1;
      r_ovr     <= 1'b0;
    end else begin
      r_rf_prev <= read_finish;
      if (w_rise && r_state != S_IDLE)
        r_ovr <= 1'b1;
    end
  end

  // raddr only moves when a new read is about to be issued
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_raddr <= '0;
      r_widx  <= '0;
      r_word  <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr  <= '0;
            r_raddr <= '0;
            r_widx  <= '0;
            r_sum   <= '0;
          end
        end
        S_CAP: begin
          r_word[{r_addr[1:0], 3'b000} +: 8]
                <= rdata;
          r_sum  <= r_sum + {8'd0, rdata};
          r_addr <= r_addr + 9'd1;
          if (r_addr[1:0] != 2'd3)
            r_raddr <= r_addr + 9'd1;
        end
        S_OUT: begin
          if (w_hs) begin
            r_widx <= r_widx + 8'd1;
            if (!w_last)
              r_raddr <= r_addr;
          end
        end
        default: ;
      endcase
    end
  end

  assign raddr     = r_raddr;
  assign word_data = r_word;
  assign checksum  = r_sum;
  assign overrun   = r_ovr;

endmodule

// File: doc/sd_sector_reader.md
# sd_sector_reader

Drains one completed SD sector from the 512-byte sector RAM of the SD top level and streams it downstream as 32-bit little-endian words with a valid/ready handshake. Sits directly downstream of the SD controller top level:
- drives that block's `raddr` and consumes `rdata`;
- is triggered by `read_finish`.

It also computes a 16-bit additive checksum of the sector for the consumer (tertiary-to-secondary storage transfer path).

## Interface
- BYTE_COUNT, 512, bytes drained per sector; multiple of 4, power of 2, 4..512.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- init_done  in  1  SD card initialised; gates start.
- read_finish  in  1  sector RAM holds a complete sector (level from SD controller).
- raddr  out  9  sector RAM read address.
- rdata  in  8  sector RAM read data; synchronous, valid the cycle after `raddr` is presented.
- word_data  out  32  packed word; byte at address 4k in bits [7:0], 4k+3 in [31:24].
- word_valid  out  1  `word_data` valid.
- word_last  out  1  high with the final word of the sector.
- word_ready  in  1  consumer accepts word.
- busy  out  1  transfer in progress (state != IDLE).
- done  out  1  one-cycle pulse after the last word is accepted.
- checksum  out  16  sum of all drained bytes mod 2^16.
- overrun  out  1  sticky: `read_finish` rose while busy.

## Operation
- Start condition: rising edge of `read_finish` (current 1, registered previous 0) while `init_done`=1 and state=IDLE.
  - A rising edge while `init_done`=0 is discarded.
  - A rising edge while busy sets `overrun` and is otherwise ignored.
  - `overrun` clears only on reset.
- States: IDLE, RD, CAP, OUT, DONE.
  - IDLE: on start, clear byte address, lane counter and checksum, then go to RD.
  - RD: `raddr` = current byte address. Go to CAP.
  - CAP:
    - Write `rdata` into byte lane (addr[1:0]).
    - checksum += rdata (16-bit, wraps).
    - Increment address.
    - If lane 3, go to OUT; else go to RD.
  - OUT: `word_valid`=1, and `word_data` holds stable until `word_ready`=1. On handshake: if this is the last word, go to DONE; else go to RD.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `word_last` = `word_valid` & (word index == BYTE_COUNT/4-1).
- `checksum` holds its final value from DONE until the next start.
- `raddr` holds its last value while in OUT/DONE/IDLE. Address arithmetic is 9-bit; it does not wrap within a sector.
- `init_done` or `read_finish` falling mid-transfer has no effect; the transfer completes.
- Reset, including mid-transfer:
  - Immediate return to IDLE.
  - All outputs 0: `raddr`=0, `word_data`=0, `word_valid`=0, `word_last`=0, `busy`=0, `done`=0, `checksum`=0, `overrun`=0.
  - The `read_finish` previous-value register is set to 1, so a level already high across reset never starts a transfer; a fresh low-to-high transition is required.

## Timing
- Cycle 0: the first cycle `read_finish`=1 is sampled with previous=0.
  - Cycle 1: RD for byte 0.
  - Cycle 2: CAP for byte 0.
  - Cycles 1..8 cover bytes 0..3 (2 cycles per byte).
  - Cycle 9: first `word_valid`=1.
- With `word_ready` tied high, each word occupies 9 cycles.
  - Last word `word_valid` at cycle 9*(BYTE_COUNT/4).
  - `done` on the following cycle: cycle 1153 for 512 bytes.
  - `busy` drops one cycle after `done`.
- Each stalled cycle (`word_ready`=0 in OUT) adds exactly one cycle. No other reads are issued during a stall.
- `busy` rises in cycle 1 and stays high through the DONE cycle.
- A start can be accepted on the first cycle back in IDLE.

## Test plan
- Sector RAM byte n = n[7:0], `word_ready`=1, `read_finish` 0→1:
  - words 0x03020100, 0x07060504, …, last 0xFFFEFDFC;
  - `word_last` only on word 127;
  - `checksum` = 0xFF00;
  - `done` at cycle 1153.
- Same data, `word_ready` low for 5 cycles on word 0 and 3 cycles on word 127:
  - `word_data` stable during each stall;
  - no `raddr` change during stalls;
  - `done` 8 cycles later (cycle 1161);
  - identical word sequence.
- All bytes 0xFF: `checksum` wraps to 0xFE00 (512*255 mod 65536); every word = 0xFFFFFFFF.
- `read_finish` rising with `init_done`=0: no `busy`, no `raddr` activity. Later `init_done`=1 with `read_finish` still high: no start. Toggling `read_finish` low then high starts a transfer.
- `read_finish` pulsed low-high mid-transfer: `overrun`=1 and stays set; transfer completes normally with 128 words.
- Reset asserted at word 40 with `read_finish` held high:
  - all outputs 0 the cycle after;
  - no restart after reset release until `read_finish` falls and rises again;
  - the new transfer starts from address 0.
